// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready and next-PC controls.
// Optional perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_pc_unit_if
`ifdef FETCH_PERF_CNT_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  branch;
    logic        eq;
    logic        rs_zero;
    logic        rs_neg;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] perf_fetched;
    logic [CNT_W-1:0] perf_taken;
`endif

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, pc_plus4, instr_valid, fetch_err,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched, perf_taken,
`endif
        input  imem_ack, imem_rdata, instr_ready, branch, eq, rs_zero, rs_neg,
        input  jump, jr, jr_target
    );

    // Memory / decode environment side
    modport slave (
        input  imem_req, imem_addr, instr, pc_plus4, instr_valid, fetch_err,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched, perf_taken,
`endif
        output imem_ack, imem_rdata, instr_ready, branch, eq, rs_zero, rs_neg,
        output jump, jr, jr_target
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and next-PC resolution stage feeding the decoder.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_taken counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_pc_unit_if.master  bus
);
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_err;

    logic        w_taken;
    logic        w_redirect;
    logic        w_accept;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

    // Branch condition from decoder code and register-compare flags
    always_comb begin
        w_taken = 1'b0;
        case (bus.branch)
            3'b001:  w_taken = bus.eq;
            3'b010:  w_taken = !bus.eq;
            3'b011:  w_taken = !bus.rs_neg && !bus.rs_zero;
            3'b100:  w_taken = !bus.rs_neg;
            3'b101:  w_taken = bus.rs_neg;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Next PC priority: jr > jump > taken branch > sequential
    always_comb begin
        w_next_pc  = r_pc_plus4;
        w_redirect = 1'b0;
        if (bus.jr) begin
            w_next_pc  = bus.jr_target;
            w_redirect = 1'b1;
        end else if (bus.jump) begin
            w_next_pc  = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
            w_redirect = 1'b1;
        end else if (w_taken) begin
            w_next_pc  = r_pc_plus4 + w_br_off;
            w_redirect = 1'b1;
        end
    end

    assign w_accept = (r_state == S_VALID) && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        r_instr    <= bus.imem_rdata;
                        r_pc_plus4 <= r_pc + 32'd4;
                        r_state    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        r_pc <= w_next_pc;
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Handshake outputs are forced low while reset is asserted
    assign bus.imem_req    = rst_n && (r_state == S_REQ);
    assign bus.instr_valid = rst_n && (r_state == S_VALID);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.pc_plus4    = r_pc_plus4;
    assign bus.fetch_err   = r_err;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_fetched;
    logic [CNT_W-1:0] r_perf_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_taken   <= '0;
        end else if (w_accept) begin
            r_perf_fetched <= r_perf_fetched + CNT_W'(1);
            if (w_redirect) begin
                r_perf_taken <= r_perf_taken + CNT_W'(1);
            end
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_taken   = r_perf_taken;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: sequential fetch, branches, jumps, stalls, error trap.
module tb_fetch_pc_unit;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_pc_unit_if bus_if ();

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        bus_if.instr_ready = 1'b0;
        bus_if.branch      = 3'b000;
        bus_if.eq          = 1'b0;
        bus_if.rs_zero     = 1'b0;
        bus_if.rs_neg      = 1'b0;
        bus_if.jump        = 1'b0;
        bus_if.jr          = 1'b0;
        bus_if.jr_target   = 32'h0;
    endtask

    // One instruction: fetch at addr (ack after dly cycles), stall in VALID, then accept with controls
    task automatic step(input logic [31:0] addr, input logic [31:0] data, input int dly, input int stall,
                        input logic [2:0] br, input logic eqv, input logic rz, input logic rn,
                        input logic jmp, input logic jrv, input logic [31:0] tgt);
        for (int i = 0; i < dly; i++) begin
            chk("req_wait", 32'(bus_if.imem_req), 32'd1);
            chk("addr_wait", bus_if.imem_addr, addr);
            @(negedge clk);
        end
        chk("req", 32'(bus_if.imem_req), 32'd1);
        chk("addr", bus_if.imem_addr, addr);
        chk("valid_lo", 32'(bus_if.instr_valid), 32'd0);
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = data;
        @(negedge clk);
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        chk("valid", 32'(bus_if.instr_valid), 32'd1);
        chk("req_lo", 32'(bus_if.imem_req), 32'd0);
        chk("instr", bus_if.instr, data);
        chk("pc_plus4", bus_if.pc_plus4, addr + 32'd4);
        for (int i = 0; i < stall; i++) begin
            bus_if.jr        = 1'b1;
            bus_if.jr_target = 32'h0000_0001;
            @(negedge clk);
            chk("stall_valid", 32'(bus_if.instr_valid), 32'd1);
            chk("stall_instr", bus_if.instr, data);
            chk("stall_pc", bus_if.imem_addr, addr);
        end
        bus_if.branch      = br;
        bus_if.eq          = eqv;
        bus_if.rs_zero     = rz;
        bus_if.rs_neg      = rn;
        bus_if.jump        = jmp;
        bus_if.jr          = jrv;
        bus_if.jr_target   = tgt;
        bus_if.instr_ready = 1'b1;
        @(negedge clk);
        clear_ctrl();
    endtask

    initial begin
        clear_ctrl();
        rst_n             = 1'b0;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_req", 32'(bus_if.imem_req), 32'd0);
        chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_instr", bus_if.instr, 32'h0);
        chk("rst_pc4", bus_if.pc_plus4, 32'h0);
        chk("rst_err", 32'(bus_if.fetch_err), 32'd0);
        chk("rst_addr", bus_if.imem_addr, 32'h0);
        @(negedge clk);
        rst_n             = 1'b1;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        @(negedge clk);
        chk("ack_in_rst_ignored", bus_if.instr, 32'h0);

        // Sequential stream, 2 cycles per instruction
        step(32'h0000_0000, 32'h2001_0000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        step(32'h0000_0004, 32'h2002_0004, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        step(32'h0000_0008, 32'h2003_0008, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        step(32'h0000_000C, 32'h2004_000C, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        // beq imm -4 taken: 0x14 - 16 = 0x04
        step(32'h0000_0010, 32'h1000_FFFC, 0, 0, 3'b001, 1, 0, 0, 0, 0, 32'h0);
        step(32'h0000_0004, 32'h0000_0000, 0, 0, 3'b000, 0, 0, 0, 0, 1, 32'h0000_0010);
        // beq not taken
        step(32'h0000_0010, 32'h1000_FFFC, 0, 0, 3'b001, 0, 0, 0, 0, 0, 32'h0);
        // Delayed ack and decode stall
        step(32'h0000_0014, 32'h1234_5678, 3, 2, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        // bgtz with rs==0: not taken
        step(32'h0000_0018, 32'h1C00_0010, 0, 0, 3'b011, 0, 1, 0, 0, 0, 32'h0);
        // bltz with rs<0: 0x20 + 0x20 = 0x40
        step(32'h0000_001C, 32'h0400_0008, 0, 0, 3'b101, 0, 0, 1, 0, 0, 32'h0);
        // branch code 111 never taken
        step(32'h0000_0040, 32'h0400_0008, 0, 0, 3'b111, 1, 0, 1, 0, 0, 32'h0);
        step(32'h0000_0044, 32'h0000_0008, 0, 0, 3'b000, 0, 0, 0, 0, 1, 32'h3000_0000);
        // jump beats taken beq
        step(32'h3000_0000, 32'h0C00_0040, 0, 0, 3'b001, 1, 0, 0, 1, 0, 32'h0);
        // jr to misaligned target traps
        step(32'h3000_0100, 32'h0000_0000, 0, 0, 3'b000, 0, 0, 0, 0, 1, 32'h0000_0102);

        for (int i = 0; i < 3; i++) begin
            chk("err_flag", 32'(bus_if.fetch_err), 32'd1);
            chk("err_req", 32'(bus_if.imem_req), 32'd0);
            chk("err_valid", 32'(bus_if.instr_valid), 32'd0);
            chk("err_addr", bus_if.imem_addr, 32'h0000_0102);
            bus_if.imem_ack    = 1'b1;
            bus_if.instr_ready = 1'b1;
            @(negedge clk);
        end
        bus_if.imem_ack    = 1'b0;
        bus_if.instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", 32'(bus_if.perf_fetched), 32'd14);
        chk("perf_taken", 32'(bus_if.perf_taken), 32'd6);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        chk("rerst_addr", bus_if.imem_addr, 32'h0);
        chk("rerst_err", 32'(bus_if.fetch_err), 32'd0);
        chk("rerst_req", 32'(bus_if.imem_req), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rerst_perf_fetched", 32'(bus_if.perf_fetched), 32'd0);
        chk("rerst_perf_taken", 32'(bus_if.perf_taken), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(bus_if.imem_req), 32'd1);
        chk("post_rst_addr", bus_if.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
